// File: rtl/usr_ctrl_pkg.sv
// Shared encodings for the universal-shift-register transfer sequencer:
// USR select codes and the controller state type.
package usr_ctrl_pkg;

   localparam logic [1:0] SEL_HOLD = 2'd0;
   localparam logic [1:0] SEL_SHR  = 2'd1;
   localparam logic [1:0] SEL_SHL  = 2'd2;
   localparam logic [1:0] SEL_LOAD = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TX_SH   = 2'd1,
      ST_RX_SH   = 2'd2,
      ST_RX_HOLD = 2'd3
   } state_t;

endpackage

// File: rtl/usr_xfer_ctrl.sv
// Sequencer owning all control inputs of a sibling W-bit universal shift register:
// parallel TX word -> serial burst on sdo, serial burst on sdi -> parallel RX word.
module usr_xfer_ctrl
   import usr_ctrl_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tx_valid,
   output logic         tx_ready,
   input  logic [W-1:0] tx_data,
   input  logic         tx_dir,
   input  logic         rx_start,
   input  logic         rx_dir,
   output logic         rx_busy,
   output logic         rx_valid,
   input  logic         rx_ready,
   output logic [W-1:0] rx_data,
   output logic         sdo,
   output logic         sdo_vld,
   input  logic         sdi,
   output logic [1:0]   usr_sel,
   output logic [W-1:0] usr_par_in,
   output logic         usr_ser_inr,
   output logic         usr_ser_inl,
   input  logic [W-1:0] usr_par_out,
   input  logic         usr_ser_outr,
   input  logic         usr_ser_outl
);

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
   localparam logic [W-1:0]  WORD_ZERO = {W{1'b0}};

   state_t          state_r, state_nxt_s;
   logic            dir_r, dir_nxt_s;
   logic [CW-1:0]   cnt_r, cnt_nxt_s;
   logic            cnt_last_s;

   assign cnt_last_s = (cnt_r == CNT_LAST);

   // State, direction and bit-counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         dir_r   <= 1'b0;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_nxt_s;
         dir_r   <= dir_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state logic; TX has priority so a concurrent rx_start waits in IDLE
   always_comb begin
      state_nxt_s = state_r;
      dir_nxt_s   = dir_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (tx_valid) begin
               state_nxt_s = ST_TX_SH;
               dir_nxt_s   = tx_dir;
               cnt_nxt_s   = CNT_ZERO;
            end else if (rx_start) begin
               state_nxt_s = ST_RX_SH;
               dir_nxt_s   = rx_dir;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_TX_SH: begin
            if (cnt_last_s) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         ST_RX_SH: begin
            if (cnt_last_s) begin
               state_nxt_s = ST_RX_HOLD;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         ST_RX_HOLD: begin
            if (rx_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RX_HOLD;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // Output decode; everything is forced quiet while rst is held
   always_comb begin
      tx_ready    = 1'b0;
      rx_busy     = 1'b0;
      rx_valid    = 1'b0;
      rx_data     = WORD_ZERO;
      sdo         = 1'b0;
      sdo_vld     = 1'b0;
      usr_sel     = SEL_HOLD;
      usr_par_in  = WORD_ZERO;
      usr_ser_inr = 1'b0;
      usr_ser_inl = 1'b0;
      if (rst) begin
         tx_ready = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               tx_ready = 1'b1;
               if (tx_valid) begin
                  usr_sel    = SEL_LOAD;
                  usr_par_in = tx_data;
               end else begin
                  usr_sel    = SEL_HOLD;
               end
            end
            ST_TX_SH: begin
               usr_sel = dir_r ? SEL_SHL : SEL_SHR;
               sdo     = dir_r ? usr_ser_outl : usr_ser_outr;
               sdo_vld = 1'b1;
            end
            ST_RX_SH: begin
               rx_busy = 1'b1;
               usr_sel = dir_r ? SEL_SHL : SEL_SHR;
               if (dir_r) begin
                  usr_ser_inl = sdi;
               end else begin
                  usr_ser_inr = sdi;
               end
            end
            ST_RX_HOLD: begin
               rx_busy  = 1'b1;
               rx_valid = 1'b1;
               rx_data  = usr_par_out;
            end
            default: begin
               usr_sel = SEL_HOLD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usr_xfer_ctrl.sv
// Directed plus randomized bench for usr_xfer_ctrl, with a behavioural USR beside it
// and expected serial/parallel values derived from word bits and transfer direction.
module tb_usr_xfer_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         tx_valid, tx_ready, tx_dir;
   logic [W-1:0] tx_data;
   logic         rx_start, rx_dir, rx_busy, rx_valid, rx_ready;
   logic [W-1:0] rx_data;
   logic         sdo, sdo_vld, sdi;
   logic [1:0]   usr_sel;
   logic [W-1:0] usr_par_in, usr_par_out;
   logic         usr_ser_inr, usr_ser_inl, usr_ser_outr, usr_ser_outl;
   logic [W-1:0] usr_q;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   usr_xfer_ctrl #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_dir(tx_dir),
      .rx_start(rx_start), .rx_dir(rx_dir), .rx_busy(rx_busy), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .rx_data(rx_data),
      .sdo(sdo), .sdo_vld(sdo_vld), .sdi(sdi),
      .usr_sel(usr_sel), .usr_par_in(usr_par_in),
      .usr_ser_inr(usr_ser_inr), .usr_ser_inl(usr_ser_inl),
      .usr_par_out(usr_par_out), .usr_ser_outr(usr_ser_outr), .usr_ser_outl(usr_ser_outl)
   );

   // Behavioural universal shift register sharing rst with the controller
   always_ff @(posedge clk or posedge rst) begin
      if (rst) usr_q <= '0;
      else begin
         case (usr_sel)
            2'd1:    usr_q <= {usr_ser_inr, usr_q[W-1:1]};
            2'd2:    usr_q <= {usr_q[W-2:0], usr_ser_inl};
            2'd3:    usr_q <= usr_par_in;
            default: usr_q <= usr_q;
         endcase
      end
   end
   assign usr_par_out  = usr_q;
   assign usr_ser_outr = usr_q[0];
   assign usr_ser_outl = usr_q[W-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Offer one word in IDLE and follow its burst; returns in the first IDLE cycle after it
   task automatic do_tx(input logic [W-1:0] data, input logic dir);
      tx_valid = 1'b1;
      tx_data  = data;
      tx_dir   = dir;
      @(negedge clk);
      chk("tx_accept_ready", tx_ready, 1);
      chk("tx_accept_sel", usr_sel, 3);
      chk("tx_accept_parin", usr_par_in, data);
      chk("tx_gap_sdo_vld", sdo_vld, 0);
      chk("tx_gap_sdo", sdo, 0);
      next_cycle();
      tx_valid = 1'b0;
      tx_data  = W'($urandom);
      tx_dir   = 1'($urandom);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         chk("tx_sdo_vld", sdo_vld, 1);
         chk("tx_sdo", sdo, dir ? data[W-1-i] : data[i]);
         chk("tx_ready_low", tx_ready, 0);
         chk("tx_rx_busy", rx_busy, 0);
         chk("tx_sel", usr_sel, dir ? 2 : 1);
         chk("tx_fill", {usr_ser_inl, usr_ser_inr}, 0);
         next_cycle();
      end
   endtask

   // Request an RX burst, feed bits LSB-of-'bits' first, then hold off the consumer
   task automatic do_rx(input logic [W-1:0] bits, input logic dir, input int hold);
      logic [W-1:0] exp;
      for (int i = 0; i < W; i++) begin
         if (dir) exp[W-1-i] = bits[i];
         else     exp[i]     = bits[i];
      end
      rx_start = 1'b1;
      rx_dir   = dir;
      rx_ready = 1'b0;
      @(negedge clk);
      chk("rx_accept_idle", tx_ready, 1);
      chk("rx_accept_busy", rx_busy, 0);
      next_cycle();
      rx_start = 1'b0;
      rx_dir   = 1'($urandom);
      for (int i = 0; i < W; i++) begin
         sdi = bits[i];
         @(negedge clk);
         chk("rx_sh_busy", rx_busy, 1);
         chk("rx_sh_valid", rx_valid, 0);
         chk("rx_sh_sel", usr_sel, dir ? 2 : 1);
         chk("rx_sh_sdo_vld", sdo_vld, 0);
         next_cycle();
      end
      sdi = 1'($urandom);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("rx_hold_valid", rx_valid, 1);
         chk("rx_hold_data", rx_data, exp);
         chk("rx_hold_sel", usr_sel, 0);
         chk("rx_hold_busy", rx_busy, 1);
         next_cycle();
      end
      rx_ready = 1'b1;
      @(negedge clk);
      chk("rx_hs_valid", rx_valid, 1);
      chk("rx_hs_data", rx_data, exp);
      next_cycle();
      rx_ready = 1'b0;
      @(negedge clk);
      chk("rx_done_valid", rx_valid, 0);
      chk("rx_done_busy", rx_busy, 0);
      chk("rx_done_data", rx_data, 0);
      chk("rx_done_ready", tx_ready, 1);
   endtask

   initial begin
      rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_dir = 1'b0;
      rx_start = 1'b0; rx_dir = 1'b0; rx_ready = 1'b0; sdi = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_rx_busy", rx_busy, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_sdo_vld", sdo_vld, 0);
      chk("rst_sdo", sdo, 0);
      chk("rst_sel", usr_sel, 0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("idle_tx_ready", tx_ready, 1);
      chk("idle_sel", usr_sel, 0);
      next_cycle();

      // 1: LSB-first 1011 -> 1,1,0,1
      do_tx(4'b1011, 1'b0);
      @(negedge clk);
      chk("t1_ready_back", tx_ready, 1);
      chk("t1_sdo_vld_off", sdo_vld, 0);
      next_cycle();

      // 2: MSB-first 1011 -> 1,0,1,1, register drained to zero
      do_tx(4'b1011, 1'b1);
      @(negedge clk);
      chk("t2_zero_fill", usr_par_out, 0);
      next_cycle();

      // 3: RX shift right 0,1,1,0 -> 0110, held for 5 cycles
      do_rx(4'b0110, 1'b0, 5);
      next_cycle();

      // 4: simultaneous TX (A) and RX request; TX first, RX accepted straight after
      rx_start = 1'b1;
      rx_dir   = 1'b1;
      do_tx(4'hA, 1'b0);
      do_rx(4'b1101, 1'b1, 1);
      next_cycle();

      // 5: back-to-back words with exactly one gap cycle
      do_tx(4'h3, 1'b0);
      do_tx(4'hC, 1'b0);
      next_cycle();

      // 6: reset mid-RX after two bits
      rx_start = 1'b1;
      rx_dir   = 1'b0;
      next_cycle();
      rx_start = 1'b0;
      sdi = 1'b1; next_cycle();
      sdi = 1'b1; next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_valid", rx_valid, 0);
      chk("t6_rst_busy", rx_busy, 0);
      next_cycle();
      rst = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         chk("t6_no_valid", rx_valid, 0);
         chk("t6_ready", tx_ready, 1);
         chk("t6_par_out", usr_par_out, 0);
         chk("t6_sel", usr_sel, 0);
         next_cycle();
      end

      // randomized mix of transfers
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(1, 0) == 1) begin
            do_tx(W'($urandom), 1'($urandom));
         end else begin
            do_rx(W'($urandom), 1'($urandom), int'($urandom_range(3, 0)));
            next_cycle();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
